ped_walk_ctrl: RTL

PED_WALK_CTRL -- requirements
Module: ped_walk_ctrl

---
 rtl/ped_walk_ctrl.sv | 150 +++++++++++++++
 1 files changed

// File: rtl/ped_walk_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : ped_walk_ctrl
// Brief    : Pedestrian walk-lamp controller slaved to an upstream traffic lamp;
//            one walk per red phase with walk, flashing don't-walk and clear.
// Revision : 1.0 - initial release
// ============================================================================
module ped_walk_ctrl #(
    parameter int WALK_CYCLES  = 8,
    parameter int FLASH_CYCLES = 4
) (
    input  logic       clock,
    input  logic       reset,
    input  logic [0:2] light,
    input  logic       ped_req,
    output logic       walk,
    output logic       dont_walk,
    output logic [7:0] countdown,
    output logic       req_ack,
    output logic       abort,
    output logic       fault
);

    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_WALK  = 3'd1,
        ST_FLASH = 3'd2,
        ST_CLEAR = 3'd3,
        ST_FAULT = 3'd4
    } state_t;

    localparam logic [7:0] CD_LOAD   = 8'(WALK_CYCLES + FLASH_CYCLES - 1);
    localparam logic [7:0] FLASH_LEN = 8'(FLASH_CYCLES);

    state_t     state_q, state_d;
    logic       req_pending_q, req_pending_d;
    logic       walk_q, walk_d;
    logic       dont_walk_q, dont_walk_d;
    logic [7:0] countdown_q, countdown_d;
    logic       req_ack_q, req_ack_d;
    logic       abort_q, abort_d;
    logic       fault_q, fault_d;

    logic       light_red;
    logic       light_valid;
    logic [7:0] countdown_dec;

    always_comb begin
        light_red     = (light == 3'b100);
        light_valid   = light_red || (light == 3'b010) || (light == 3'b001);
        countdown_dec = (countdown_q == 8'd0) ? 8'd0 : countdown_q - 8'd1;
    end

    always_comb begin
        state_d       = state_q;
        req_pending_d = req_pending_q | (ped_req & (state_q != ST_WALK));
        walk_d        = 1'b0;
        dont_walk_d   = 1'b1;
        countdown_d   = 8'd0;
        req_ack_d     = 1'b0;
        abort_d       = 1'b0;
        fault_d       = 1'b0;

        // An invalid lamp code outranks every state-specific transition.
        if (!light_valid) begin
            state_d = ST_FAULT;
            fault_d = 1'b1;
        end else begin
            case (state_q)
                ST_IDLE: begin
                    if (light_red && (req_pending_q || ped_req)) begin
                        state_d       = ST_WALK;
                        req_pending_d = 1'b0;
                        req_ack_d     = 1'b1;
                        walk_d        = 1'b1;
                        dont_walk_d   = 1'b0;
                        countdown_d   = CD_LOAD;
                    end
                end
                ST_WALK: begin
                    if (!light_red) begin
                        state_d = ST_IDLE;
                        abort_d = 1'b1;
                    end else if (countdown_q == FLASH_LEN) begin
                        // Countdown equals the flash length exactly when the walk time is used up.
                        state_d     = ST_FLASH;
                        countdown_d = countdown_dec;
                    end else begin
                        walk_d      = 1'b1;
                        dont_walk_d = 1'b0;
                        countdown_d = countdown_dec;
                    end
                end
                ST_FLASH: begin
                    if (!light_red) begin
                        state_d = ST_IDLE;
                        abort_d = 1'b1;
                    end else if (countdown_q == 8'd0) begin
                        state_d = ST_CLEAR;
                    end else begin
                        dont_walk_d = ~dont_walk_q;
                        countdown_d = countdown_dec;
                    end
                end
                ST_CLEAR: begin
                    if (!light_red) begin
                        state_d = ST_IDLE;
                    end
                end
                ST_FAULT: begin
                    state_d = ST_IDLE;
                end
                default: begin
                    state_d = ST_IDLE;
                end
            endcase
        end
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            state_q       <= ST_IDLE;
            req_pending_q <= 1'b0;
            walk_q        <= 1'b0;
            dont_walk_q   <= 1'b1;
            countdown_q   <= 8'd0;
            req_ack_q     <= 1'b0;
            abort_q       <= 1'b0;
            fault_q       <= 1'b0;
        end else begin
            state_q       <= state_d;
            req_pending_q <= req_pending_d;
            walk_q        <= walk_d;
            dont_walk_q   <= dont_walk_d;
            countdown_q   <= countdown_d;
            req_ack_q     <= req_ack_d;
            abort_q       <= abort_d;
            fault_q       <= fault_d;
        end
    end

    assign walk      = walk_q;
    assign dont_walk = dont_walk_q;
    assign countdown = countdown_q;
    assign req_ack   = req_ack_q;
    assign abort     = abort_q;
    assign fault     = fault_q;

endmodule
`default_nettype wire
